cdiv: RTL and testbench
=======================

Name: cdiv

Overview:
- Iterative Q1.15 complex divider: C = A / B for packed {real, imag} operands.
- Sits beside the pipelined complex multiplier in the FFT datapath. Used for normalisation and equalisation, where the multiplier's result must be undone.
- Accepts one operation at a time over a valid/ready handshake.
- Multi-cycle: three setup stages, then bit-serial restoring division of both components in parallel.

Parameters:
word_size, 16, width of one Q1.(word_size-1) component; operands/result are 2*word_size wide

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
i_valid  input  1  operand pair valid
i_ready  output  1  block idle, can accept
A  input  2*word_size  dividend {Ar[2w-1:w], Ai[w-1:0]}, signed Q1.15
B  input  2*word_size  divisor {Br, Bi}, signed Q1.15
o_valid  output  1  result valid, held until accepted
o_ready  input  1  downstream accepts result
C  output  2*word_size  quotient {Cr, Ci}, signed Q1.15
o_sat  output  1  at least one component saturated
o_dz  output  1  divide by zero (B == 0)

Behaviour:
- Reset (async, reset_n=0): state IDLE; i_ready=1, o_valid=0, C=0, o_sat=0, o_dz=0; all internal registers cleared. A reset mid-operation aborts the operation; no result is produced.
- FSM states: IDLE, MUL, SUM, CHK, DIV, DONE.
- IDLE:
  - i_ready=1.
  - On i_valid, latch A and B and go to MUL.
  - i_ready=0 in every other state.
- MUL: register four signed 2w-bit products: ArBr, AiBi, ArBi, AiBr. Go to SUM.
- SUM: register, as signed 2w+1-bit values:
  - Nr = ArBr + AiBi
  - Ni = AiBr - ArBi
  - D = Br² + Bi² (the two squares are computed in this cycle).
  - Go to CHK.
- CHK:
  - If D == 0: set C=0, o_dz=1, o_sat=0, go to DONE.
  - Otherwise record the signs of Nr and Ni and take the magnitudes |Nr| and |Ni|.
  - Set the per-component saturation flag when |N| >= D.
  - Load both restoring dividers and go to DIV.
- DIV:
  - Each cycle produces one quotient bit per component, in parallel: remainder shifted left 1, compare with D, subtract when ≥.
  - Runs word_size-1 iterations, giving magnitude q = floor(|N|·2^(w-1)/D).
  - On the final iteration, form the result per component:
    - saturated and positive → 0x7FFF
    - saturated and negative → 0x8000
    - else ±q, i.e. sign-magnitude truncation toward zero
  - Go to DONE.
- DONE:
  - o_valid=1. C, o_sat and o_dz are stable until the handshake completes.
  - On o_ready, go to IDLE at the next edge, with o_valid=0 after that edge.
  - No acceptance in DONE; the minimum spacing between operations is one IDLE cycle.
- Latency, counting clock edges from the accepting edge until o_valid is high:
  - normal: word_size+2 (18 at default)
  - divide by zero: 3
- o_sat = OR of the two component flags. An exact -1 result (|N|==D, negative) yields 0x8000 with o_sat=1.
- Internal widths:
  - D and the magnitudes are unsigned 2w+1 bits.
  - The remainder register is 2w+2 bits, so no intermediate overflow occurs.
- Inputs A/B are sampled only on the accepting edge; changes afterwards are ignored.
- Iteration counter: ceil(log2(word_size)) bits; it resets to 0 on entering DIV.

Optional Feature:
- Macro: CDIV_ROUND_EN.
- Defined:
  - DIV runs word_size iterations; the extra bit is the half-LSB guard.
  - Result magnitude = (q_ext + 1) >> 1, i.e. round half away from zero.
  - If rounding carries the magnitude to 2^(w-1), clamp: positive → 0x7FFF with o_sat=1; negative → 0x8000 with o_sat=1.
  - Normal latency becomes word_size+3.
- Undefined: truncation toward zero as above; latency word_size+2.

Test Plan:
- A={0x2000,0x0000}, B={0x4000,0x0000} → C={0x4000,0x0000}, o_sat=0, o_dz=0, o_valid 18 edges after accept.
- A={0x2000,0x2000}, B={0x0000,0x4000} → C={0x4000,0xC000} (0.5-0.5j), o_sat=0.
- A={0x2000,0}, B={0x6000,0} → Cr=0x2AAA without macro; Cr=0x2AAB with CDIV_ROUND_EN (latency 19). Negated A → Cr=0xD556 (truncated) / 0xD555 (rounded).
- Saturation and zero divisor:
  - A={0x4000,0}, B={0x2000,0} → C={0x7FFF,0x0000}, o_sat=1.
  - A={0xC000,0}, B={0x4000,0} → Cr=0x8000, o_sat=1.
  - B=0 → C=0, o_dz=1 after 3 edges.
- Hold o_ready=0 for 10 cycles in DONE → o_valid and C stable, i_ready=0. Pulse o_ready → IDLE next edge; a back-to-back i_valid is accepted one cycle later.
- Assert reset_n=0 mid-DIV (asynchronously, between edges) → o_valid=0, i_ready=1 immediately. The next operation completes correctly with full latency.

Source files
------------

// File: rtl/cdiv.sv
`timescale 1ns/1ps
// cdiv: iterative signed Q1.(word_size-1) complex divider, C = A / B.
// Three setup stages (MUL, SUM, CHK) followed by a bit-serial restoring
// division of the real and imaginary numerators in parallel.
// Build macro CDIV_ROUND_EN: one extra quotient bit, round half away from
// zero instead of truncation toward zero (one extra cycle of latency).
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. Input side: i_ready is high only in IDLE, and A/B are
// sampled on that edge only. Output side: o_valid rises in DONE and C, o_sat
// and o_dz hold steady until the edge where o_ready is seen high.
module cdiv #(
    parameter int word_size = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [2*word_size-1:0] A,
    input  logic [2*word_size-1:0] B,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [2*word_size-1:0] C,
    output logic                   o_sat,
    output logic                   o_dz,
    output logic [2:0]             dbg_state
);

    localparam int W  = word_size;
    localparam int PW = 2 * W;      // product width
    localparam int NW = 2 * W + 1;  // numerator / denominator width
    localparam int RW = 2 * W + 2;  // remainder width, headroom for the shift
    localparam int CW = $clog2(W);  // iteration counter width
`ifdef CDIV_ROUND_EN
    localparam int ITERS = W;       // extra bit is the half-LSB guard
`else
    localparam int ITERS = W - 1;
`endif
    localparam int QW = ITERS;
    localparam logic [CW-1:0] LAST_ITER = CW'(ITERS - 1);
    localparam logic [W-1:0]  MAX_POS   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  MAX_NEG   = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_SUM  = 3'd2,
        S_CHK  = 3'd3,
        S_DIV  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t state, state_nxt;

    // Latched operands and setup-stage registers
    logic [PW-1:0]        a_q, b_q;
    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [NW-1:0] nr_q, ni_q;
    logic [NW-1:0]        d_q;

    // Divider state
    logic                 neg_r, neg_i, sat_r, sat_i;
    logic [RW-1:0]        rem_r, rem_i;
    logic [QW-1:0]        q_r, q_i;
    logic [CW-1:0]        cnt;

    // Component views, sign-extended to product width
    logic signed [W-1:0]  ar, ai, br, bi;
    logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x;
    logic signed [PW-1:0] sq_r, sq_i;

    assign ar   = a_q[PW-1:W];
    assign ai   = a_q[W-1:0];
    assign br   = b_q[PW-1:W];
    assign bi   = b_q[W-1:0];
    assign ar_x = {{W{ar[W-1]}}, ar};
    assign ai_x = {{W{ai[W-1]}}, ai};
    assign br_x = {{W{br[W-1]}}, br};
    assign bi_x = {{W{bi[W-1]}}, bi};
    assign sq_r = br_x * br_x;
    assign sq_i = bi_x * bi_x;

    // Magnitudes of the numerators and one restoring step per component
    logic [NW-1:0] mag_r, mag_i;
    logic [RW-1:0] sh_r, sh_i, rem_r_nxt, rem_i_nxt, d_ext;
    logic          ge_r, ge_i;
    logic [QW-1:0] q_r_nxt, q_i_nxt;
    logic [W:0]    res_r, res_i;

    // Turns a quotient magnitude into a signed component plus saturation flag
    function automatic logic [W:0] form_result(input logic neg, input logic sat,
                                               input logic [QW-1:0] q);
        logic [W-1:0] mag;
        logic         ovf;
`ifdef CDIV_ROUND_EN
        logic [W:0]   inc;
        inc = {1'b0, q} + (W+1)'(1);
        mag = inc[W:1];
        ovf = mag[W-1];
`else
        mag = {1'b0, q};
        ovf = 1'b0;
`endif
        if (sat || ovf)
            form_result = {1'b1, (neg ? MAX_NEG : MAX_POS)};
        else
            form_result = {1'b0, (neg ? (~mag + W'(1)) : mag)};
    endfunction

    // Datapath combinational helpers for CHK and DIV
    always_comb begin
        mag_r     = nr_q[NW-1] ? (~nr_q + NW'(1)) : nr_q;
        mag_i     = ni_q[NW-1] ? (~ni_q + NW'(1)) : ni_q;
        d_ext     = {1'b0, d_q};
        sh_r      = {rem_r[RW-2:0], 1'b0};
        sh_i      = {rem_i[RW-2:0], 1'b0};
        ge_r      = (sh_r >= d_ext);
        ge_i      = (sh_i >= d_ext);
        rem_r_nxt = ge_r ? (sh_r - d_ext) : sh_r;
        rem_i_nxt = ge_i ? (sh_i - d_ext) : sh_i;
        q_r_nxt   = {q_r[QW-2:0], ge_r};
        q_i_nxt   = {q_i[QW-2:0], ge_i};
        res_r     = form_result(neg_r, sat_r, q_r_nxt);
        res_i     = form_result(neg_i, sat_i, q_i_nxt);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_nxt = state;
        i_ready   = 1'b0;
        o_valid   = 1'b0;
        case (state)
            S_IDLE: begin
                i_ready = 1'b1;
                if (i_valid) state_nxt = S_MUL;
            end
            S_MUL: state_nxt = S_SUM;
            S_SUM: state_nxt = S_CHK;
            S_CHK: state_nxt = (d_q == '0) ? S_DONE : S_DIV;
            S_DIV: if (cnt == LAST_ITER) state_nxt = S_DONE;
            S_DONE: begin
                o_valid = 1'b1;
                if (o_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign dbg_state = state;

    // Datapath: operand capture, setup stages, iterative division, result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q   <= '0;
            b_q   <= '0;
            p_rr  <= '0;
            p_ii  <= '0;
            p_ri  <= '0;
            p_ir  <= '0;
            nr_q  <= '0;
            ni_q  <= '0;
            d_q   <= '0;
            neg_r <= 1'b0;
            neg_i <= 1'b0;
            sat_r <= 1'b0;
            sat_i <= 1'b0;
            rem_r <= '0;
            rem_i <= '0;
            q_r   <= '0;
            q_i   <= '0;
            cnt   <= '0;
            C     <= '0;
            o_sat <= 1'b0;
            o_dz  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        a_q <= A;
                        b_q <= B;
                    end
                end
                S_MUL: begin
                    p_rr <= ar_x * br_x;
                    p_ii <= ai_x * bi_x;
                    p_ri <= ar_x * bi_x;
                    p_ir <= ai_x * br_x;
                end
                S_SUM: begin
                    nr_q <= {p_rr[PW-1], p_rr} + {p_ii[PW-1], p_ii};
                    ni_q <= {p_ir[PW-1], p_ir} - {p_ri[PW-1], p_ri};
                    d_q  <= {1'b0, sq_r} + {1'b0, sq_i};
                end
                S_CHK: begin
                    if (d_q == '0) begin
                        C     <= '0;
                        o_dz  <= 1'b1;
                        o_sat <= 1'b0;
                    end else begin
                        neg_r <= nr_q[NW-1];
                        neg_i <= ni_q[NW-1];
                        sat_r <= (mag_r >= d_q);
                        sat_i <= (mag_i >= d_q);
                        rem_r <= {1'b0, mag_r};
                        rem_i <= {1'b0, mag_i};
                        q_r   <= '0;
                        q_i   <= '0;
                        cnt   <= '0;
                    end
                end
                S_DIV: begin
                    rem_r <= rem_r_nxt;
                    rem_i <= rem_i_nxt;
                    q_r   <= q_r_nxt;
                    q_i   <= q_i_nxt;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST_ITER) begin
                        C     <= {res_r[W-1:0], res_i[W-1:0]};
                        o_sat <= res_r[W] | res_i[W];
                        o_dz  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cdiv.sv
`timescale 1ns/1ps
// tb_cdiv: directed and randomized checks of the cdiv complex divider
// against an arithmetic reference model.
module tb_cdiv;

  localparam int W = 16;
`ifdef CDIV_ROUND_EN
  localparam int LAT_NORM = W + 3;
  localparam logic [15:0] CR_THIRD = 16'h2AAB;
  localparam logic [15:0] CR_NTHIRD = 16'hD555;
`else
  localparam int LAT_NORM = W + 2;
  localparam logic [15:0] CR_THIRD = 16'h2AAA;
  localparam logic [15:0] CR_NTHIRD = 16'hD556;
`endif
  localparam int LAT_DZ = 3;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] A, B;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] C;
  logic        o_sat;
  logic        o_dz;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cdiv #(.word_size(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_valid(i_valid), .i_ready(i_ready),
    .A(A), .B(B),
    .o_valid(o_valid), .o_ready(o_ready),
    .C(C), .o_sat(o_sat), .o_dz(o_dz),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];  // {sat, dz, C}

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_comp(input longint n, input longint d,
                            output logic [15:0] c, output logic s);
    longint m, q;
    m = (n < 0) ? -n : n;
    s = 1'b0;
    c = 16'h0000;
    if (m >= d) begin
      s = 1'b1;
      c = (n < 0) ? 16'h8000 : 16'h7FFF;
    end else begin
`ifdef CDIV_ROUND_EN
      q = (((m << 16) / d) + 1) / 2;
`else
      q = (m << 15) / d;
`endif
      if (q >= 32768) begin
        s = 1'b1;
        c = (n < 0) ? 16'h8000 : 16'h7FFF;
      end else begin
        c = (n < 0) ? 16'(-q) : 16'(q);
      end
    end
  endtask

  task automatic model(input logic [31:0] a, input logic [31:0] b, output logic [33:0] r);
    longint ar, ai, br, bi, nr, ni, d;
    logic [15:0] cr, ci;
    logic sr, si;
    ar = longint'($signed(a[31:16]));
    ai = longint'($signed(a[15:0]));
    br = longint'($signed(b[31:16]));
    bi = longint'($signed(b[15:0]));
    nr = ar * br + ai * bi;
    ni = ai * br - ar * bi;
    d  = br * br + bi * bi;
    if (d == 0) begin
      r = {1'b0, 1'b1, 32'h0};
    end else begin
      model_comp(nr, d, cr, sr);
      model_comp(ni, d, ci, si);
      r = {sr | si, 1'b0, cr, ci};
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int g;
    @(negedge clk);
    i_valid = 1'b1;
    A = a;
    B = b;
    g = 0;
    while (!i_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("accept_ready", 64'(i_ready), 64'(1));
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    A = $urandom;
    B = $urandom;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!o_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input int exp_lat);
    int lat;
    logic [33:0] e;
    wait_result(lat);
    e = exp_q.pop_front();
    check("latency", 64'(lat), 64'(e[32] ? LAT_DZ : exp_lat));
    check("result_c", 64'(C), 64'(e[31:0]));
    check("result_sat", 64'(o_sat), 64'(e[33]));
    check("result_dz", 64'(o_dz), 64'(e[32]));
    check("done_iready", 64'(i_ready), 64'(0));
  endtask

  task automatic release_result();
    @(negedge clk);
    o_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rel_ovalid", 64'(o_valid), 64'(0));
    check("rel_iready", 64'(i_ready), 64'(1));
    o_ready = 1'b0;
  endtask

  task automatic run_directed(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] ec, input logic es, input logic ed);
    exp_q.push_back({es, ed, ec});
    send(a, b);
    check_result(LAT_NORM);
    release_result();
  endtask

  task automatic run_model(input logic [31:0] a, input logic [31:0] b);
    logic [33:0] r;
    model(a, b, r);
    exp_q.push_back(r);
    send(a, b);
    check_result(LAT_NORM);
    release_result();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] a, b, c_hold;
    logic [33:0] r;
    int sel;

    reset_n = 1'b0;
    i_valid = 1'b0;
    o_ready = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_iready", 64'(i_ready), 64'(1));
    check("reset_ovalid", 64'(o_valid), 64'(0));
    check("reset_c", 64'(C), 64'(0));
    check("reset_sat", 64'(o_sat), 64'(0));
    check("reset_dz", 64'(o_dz), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Basic quotients
    run_directed(32'h2000_0000, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0);
    run_directed(32'h2000_2000, 32'h0000_4000, 32'h4000_C000, 1'b0, 1'b0);
    // One third: truncation vs rounding
    run_directed(32'h2000_0000, 32'h6000_0000, {CR_THIRD, 16'h0000}, 1'b0, 1'b0);
    run_directed(32'hE000_0000, 32'h6000_0000, {CR_NTHIRD, 16'h0000}, 1'b0, 1'b0);
    // Saturation, including exact -1
    run_directed(32'h4000_0000, 32'h2000_0000, 32'h7FFF_0000, 1'b1, 1'b0);
    run_directed(32'hC000_0000, 32'h4000_0000, 32'h8000_0000, 1'b1, 1'b0);
    // Divide by zero
    run_directed(32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);

    // Hold in DONE, then release with a back-to-back request
    exp_q.push_back({1'b0, 1'b0, 32'h4000_0000});
    send(32'h2000_0000, 32'h4000_0000);
    check_result(LAT_NORM);
    c_hold = C;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check("hold_ovalid", 64'(o_valid), 64'(1));
      check("hold_c", 64'(C), 64'(32'h4000_0000));
      check("hold_iready", 64'(i_ready), 64'(0));
    end
    check("hold_c_stable", 64'(C), 64'(c_hold));
    @(negedge clk);
    o_ready = 1'b1;
    i_valid = 1'b1;
    A = 32'h2000_2000;
    B = 32'h0000_4000;
    @(posedge clk);
    #1;
    check("b2b_ovalid", 64'(o_valid), 64'(0));
    check("b2b_iready", 64'(i_ready), 64'(1));
    o_ready = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_accepted", 64'(i_ready), 64'(0));
    i_valid = 1'b0;
    A = $urandom;
    B = $urandom;
    exp_q.push_back({1'b0, 1'b0, 32'h4000_C000});
    check_result(LAT_NORM);
    release_result();

    // Asynchronous reset in the middle of the division
    send(32'h1111_2222, 32'h3333_4444);
    repeat (8) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_ovalid", 64'(o_valid), 64'(0));
    check("midreset_iready", 64'(i_ready), 64'(1));
    check("midreset_c", 64'(C), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    check("midreset_hold_ovalid", 64'(o_valid), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    run_directed(32'h2000_0000, 32'h6000_0000, {CR_THIRD, 16'h0000}, 1'b0, 1'b0);

    // Randomized operands against the reference model
    for (int k = 0; k < 40; k++) begin
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 3);
      if (sel == 1) b = {{6{b[31]}}, b[25:16], {6{b[15]}}, b[9:0]};
      if (sel == 2) a = {{6{a[31]}}, a[25:16], {6{a[15]}}, a[9:0]};
      if (k % 13 == 5) b = 32'h0;
      run_model(a, b);
    end

    // Model cross-check of a fixed corner: most negative operands
    model(32'h8000_8000, 32'h8000_8000, r);
    exp_q.push_back(r);
    send(32'h8000_8000, 32'h8000_8000);
    check_result(LAT_NORM);
    release_result();

    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
